// File: rtl/fir_sched_pkg.sv
// Shared encodings and widths for the two-channel time-shared FIR scheduler.
package fir_sched_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WAIT_W   = 4;
  localparam int DEC_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer remembers the last winner so a
// tie goes to the other channel.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_ch,
  output logic       take
);

  logic last;

  always_comb begin
    gnt_ch = (req == 2'b11) ? ~last : req[1];
    gnt[0] = en & req[0] & ~gnt_ch;
    gnt[1] = en & req[1] & gnt_ch;
  end

  assign take = |gnt;

  // Pointer starts at 1 so channel 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take) begin
      last <= gnt_ch;
    end
  end

endmodule

// File: rtl/fir_ch_sched.sv
// Schedules two sample streams through one shared FIR with per-channel state
// banks and decimates each channel's filtered results independently.
module fir_ch_sched
  import fir_sched_pkg::*;
#(
  parameter int DECIM    = 8,
  parameter int FILT_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ch0_valid,
  input  logic signed [SAMPLE_W-1:0] ch0_data,
  output logic                       ch0_ready,
  input  logic                       ch1_valid,
  input  logic signed [SAMPLE_W-1:0] ch1_data,
  output logic                       ch1_ready,
  output logic signed [SAMPLE_W-1:0] filt_data,
  output logic                       filt_enable,
  output logic                       filt_sel,
  input  logic signed [SAMPLE_W-1:0] filt_out,
  output logic                       out_valid,
  output logic                       out_ch,
  output logic signed [SAMPLE_W-1:0] out_data,
  input  logic                       out_ready
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(FILT_LAT - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECIM - 1);

  sched_state_t      state, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic [DEC_W-1:0]  dec [2];
  logic [1:0]        gnt;
  logic              gnt_ch;
  logic              take;
  logic              wait_done;
  logic              dec_final;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state == ST_IDLE),
    .req    ({ch1_valid, ch0_valid}),
    .gnt    (gnt),
    .gnt_ch (gnt_ch),
    .take   (take)
  );

  assign ch0_ready   = gnt[0];
  assign ch1_ready   = gnt[1];
  assign filt_enable = (state == ST_ISSUE);
  assign out_valid   = (state == ST_HOLD);
  assign wait_done   = (state == ST_WAIT) && (wait_cnt == '0);
  assign dec_final   = (dec[filt_sel] == DEC_LAST);

  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (take) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d    = ST_WAIT;
        wait_cnt_d = WAIT_LOAD;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          state_d = dec_final ? ST_HOLD : ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // Sample and bank select hold from one transfer to the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_data <= '0;
      filt_sel  <= 1'b0;
    end else if (take) begin
      filt_data <= gnt_ch ? ch1_data : ch0_data;
      filt_sel  <= gnt_ch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec[0] <= '0;
      dec[1] <= '0;
    end else if (wait_done) begin
      dec[filt_sel] <= dec_final ? '0 : dec[filt_sel] + 1'b1;
    end
  end

  // Filter output is valid on the last WAIT cycle; capture only the kept sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_ch   <= 1'b0;
    end else if (wait_done && dec_final) begin
      out_data <= filt_out;
      out_ch   <= filt_sel;
    end
  end

endmodule

// File: tb/tb_fir_ch_sched.sv
// Scoreboard bench for fir_ch_sched: a DECIM=8 instance with a behavioural
// shared filter, plus a DECIM=1 instance for exact latency checks.
module tb_fir_ch_sched;

  localparam int DECIM = 8;
  localparam int FLAT  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance
  logic        c0v, c1v, c0r, c1r, fe, fs, ov, och, ordy;
  logic [15:0] c0d, c1d, fd, fo, od;

  fir_ch_sched #(.DECIM(DECIM), .FILT_LAT(FLAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_valid(c0v), .ch0_data(c0d), .ch0_ready(c0r),
    .ch1_valid(c1v), .ch1_data(c1d), .ch1_ready(c1r),
    .filt_data(fd), .filt_enable(fe), .filt_sel(fs), .filt_out(fo),
    .out_valid(ov), .out_ch(och), .out_data(od), .out_ready(ordy)
  );

  // Latency instance with DECIM=1; its filter output is a cycle-stamped value
  logic        e_c0v, e_c1v, e_c0r, e_c1r, e_fe, e_fs, e_ov, e_och, e_ordy;
  logic [15:0] e_c0d, e_c1d, e_fd, e_fo, e_od;
  assign e_fo = 16'(cyc * 3 + 7);

  fir_ch_sched #(.DECIM(1), .FILT_LAT(2)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .ch0_valid(e_c0v), .ch0_data(e_c0d), .ch0_ready(e_c0r),
    .ch1_valid(e_c1v), .ch1_data(e_c1d), .ch1_ready(e_c1r),
    .filt_data(e_fd), .filt_enable(e_fe), .filt_sel(e_fs), .filt_out(e_fo),
    .out_valid(e_ov), .out_ch(e_och), .out_data(e_od), .out_ready(e_ordy)
  );

  function automatic logic [15:0] filt_f(input logic [15:0] x, input logic s);
    return x ^ (s ? 16'h0F0F : 16'h5A5A);
  endfunction

  // Behavioural shared filter: result appears FLAT cycles after the enable cycle
  logic [16:0] fpipe [FLAT] = '{default: '0};
  always @(posedge clk) begin
    fpipe[0] <= {fe, filt_f(fd, fs)};
    for (int i = 1; i < FLAT; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fo = fpipe[FLAT-1][16] ? fpipe[FLAT-1][15:0] : 16'h7BAD;

  typedef struct packed {
    logic        ch;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] q0[$], q1[$];
  int          acc_log[$];
  int          n_cmp = 0, n_err = 0, n_out = 0, n_acc = 0;
  int          cnt0 = 0, cnt1 = 0;
  logic        exp_fe = 1'b0, exp_fs = 1'b0;
  logic [15:0] exp_fd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    c0v = (q0.size() > 0);
    c0d = c0v ? q0[0] : 16'h0;
    c1v = (q1.size() > 0);
    c1d = c1v ? q1[0] : 16'h0;
  endtask

  task automatic accept(input logic ch, input logic [15:0] d);
    exp_t e;
    n_acc++;
    acc_log.push_back(int'(ch));
    exp_fe = 1'b1;
    exp_fd = d;
    exp_fs = ch;
    e.ch = ch;
    e.d  = filt_f(d, ch);
    if (ch) begin
      cnt1++;
      if (cnt1 == DECIM) begin cnt1 = 0; sb.push_back(e); end
    end else begin
      cnt0++;
      if (cnt0 == DECIM) begin cnt0 = 0; sb.push_back(e); end
    end
  endtask

  task automatic do_cycle();
    exp_t        e;
    logic [15:0] d;
    @(negedge clk);
    chk("filt_enable", fe, exp_fe);
    if (exp_fe) begin
      chk("filt_data", fd, exp_fd);
      chk("filt_sel", fs, exp_fs);
    end
    exp_fe = 1'b0;
    chk("ready_excl", c0r & c1r, 1'b0);
    if (ov && ordy) begin
      if (sb.size() == 0) begin
        chk("out_unexpected", ov, 1'b0);
      end else begin
        e = sb.pop_front();
        chk("out_ch", och, e.ch);
        chk("out_data", od, e.d);
        n_out++;
      end
    end
    if (c0v && c0r) begin d = q0.pop_front(); accept(1'b0, d); end
    if (c1v && c1r) begin d = q1.pop_front(); accept(1'b1, d); end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((q0.size() + q1.size() + sb.size()) != 0 && b < 8000) begin
      do_cycle();
      b++;
    end
    chk("drain_budget", q0.size() + q1.size() + sb.size(), 0);
    repeat (8) do_cycle();
  endtask

  task automatic reset_model();
    cnt0 = 0; cnt1 = 0;
    sb.delete(); q0.delete(); q1.delete();
    exp_fe = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_fd"}, fd, 0);
    chk({tag, "_fs"}, fs, 0);
    chk({tag, "_fe"}, fe, 0);
    chk({tag, "_ov"}, ov, 0);
    chk({tag, "_och"}, och, 0);
    chk({tag, "_od"}, od, 0);
    chk({tag, "_rdy"}, {c1r, c0r}, 0);
  endtask

  initial begin
    int t0, n0, a0;
    rst_n = 1'b0;
    ordy  = 1'b1;
    drive();
    e_c0v = 0; e_c1v = 0; e_c0d = '0; e_c1d = '0; e_ordy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Exact latency on the DECIM=1 instance, one sample per channel
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      e_c0v = (c == 0); e_c1v = (c == 1);
      e_c0d = 16'h4000; e_c1d = 16'hC123;
      @(negedge clk);
      t0 = cyc;
      chk("d1_ready", (c == 1) ? e_c1r : e_c0r, 1'b1);
      chk("d1_other_ready", (c == 1) ? e_c0r : e_c1r, 1'b0);
      @(posedge clk); #1;
      e_c0v = 0; e_c1v = 0;
      @(negedge clk);
      chk("d1_fe_t1", e_fe, 1'b1);
      chk("d1_fd", e_fd, (c == 1) ? 16'hC123 : 16'h4000);
      chk("d1_fs", e_fs, c);
      @(negedge clk);
      chk("d1_fe_t2", e_fe, 1'b0);
      chk("d1_ov_t2", e_ov, 1'b0);
      @(negedge clk);
      chk("d1_ov_t3", e_ov, 1'b0);
      @(negedge clk);
      chk("d1_ov_t4", e_ov, 1'b1);
      chk("d1_och", e_och, c);
      chk("d1_od", e_od, 16'((t0 + 3) * 3 + 7));
      @(negedge clk);
      chk("d1_ov_t5", e_ov, 1'b0);
    end

    // Tie arbitration: both channels valid from the start
    repeat (2) begin q0.push_back(16'h0101 + 16'(q0.size())); q1.push_back(16'h0202 + 16'(q1.size())); end
    for (int i = 0; i < 100 && acc_log.size() < 4; i++) do_cycle();
    chk("tie_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < acc_log.size()) chk("tie_grant", acc_log[i], i % 2);
    drain();

    // Independent per-channel decimation: ch0 needs 6 more, ch1 14 more
    for (int k = 0; k < 6; k++)  q0.push_back(16'h1100 + 16'(k));
    for (int k = 0; k < 14; k++) q1.push_back(16'h8200 - 16'(k * 37));
    n0 = n_out;
    drain();
    chk("indep_outputs", n_out - n0, 3);

    // Decimation by 8 of a 100-sample-period sine on ch0
    for (int i = 0; i < 1000; i++) begin
      real r;
      r = 16000.0 * $sin(6.283185307179586 * i / 100.0);
      q0.push_back(16'($rtoi(r)));
    end
    n0 = n_out;
    drain();
    chk("sine_outputs", n_out - n0, 125);

    // Backpressure in HOLD
    ordy = 1'b0;
    for (int k = 0; k < 8; k++) q0.push_back(16'h3300 + 16'(k));
    for (int i = 0; i < 200 && !ov; i++) do_cycle();
    chk("bp_reach_hold", ov, 1'b1);
    for (int k = 0; k < 3; k++) q1.push_back(16'h4400 + 16'(k));
    for (int i = 0; i < 20; i++) begin
      do_cycle();
      #1;
      chk("bp_ov", ov, 1'b1);
      if (sb.size() > 0) begin
        chk("bp_od", od, sb[0].d);
        chk("bp_och", och, sb[0].ch);
      end
      chk("bp_ready", {c1r, c0r}, 2'b00);
      chk("bp_fe", fe, 1'b0);
    end
    ordy = 1'b1;
    do_cycle();
    #1;
    chk("bp_release_ov", ov, 1'b0);
    chk("bp_release_ready", c1r, 1'b1);
    drain();

    // Reset during WAIT aborts the in-flight sample and clears decimation
    for (int k = 0; k < 5; k++) q0.push_back(16'h5500 + 16'(k));
    drain();
    q0.push_back(16'h2222);
    a0 = n_acc;
    for (int i = 0; i < 50 && n_acc == a0; i++) do_cycle();
    chk("rst_accept", n_acc - a0, 1);
    do_cycle();
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    reset_model();
    repeat (3) do_cycle();
    rst_n = 1'b1;
    n0 = n_out;
    for (int k = 0; k < 8; k++) q0.push_back(16'h6600 + 16'(k));
    drain();
    chk("rst_dec_restart", n_out - n0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_ch_sched.md
FIR_CH_SCHED -- requirements
Module: fir_ch_sched

Interface
REQ-001 Parameter DECIM, default 8: filtered samples per channel between emitted outputs; legal range 1..256.
REQ-002 Parameter FILT_LAT, default 2: cycles from the FILT_ENABLE cycle to FILT_OUT valid; legal range 1..15.
REQ-003 CLK  input  1  single clock; all logic on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 CH0_VALID  input  1  channel 0 sample offered.
REQ-006 CH0_DATA  input  16 signed Q1.15  channel 0 sample.
REQ-007 CH0_READY  output  1  channel 0 sample accepted this cycle.
REQ-008 CH1_VALID / CH1_DATA / CH1_READY: identical to REQ-005..007, for channel 1.
REQ-009 FILT_DATA  output  16 signed  sample driven to the shared filter input.
REQ-010 FILT_ENABLE  output  1  one-cycle strobe advancing the shared filter.
REQ-011 FILT_SEL  output  1  channel whose filter state bank is active.
REQ-012 FILT_OUT  input  16 signed  shared filter output.
REQ-013 OUT_VALID  output  1  decimated result available.
REQ-014 OUT_CH  output  1  channel tag of OUT_DATA.
REQ-015 OUT_DATA  output  16 signed  decimated result.
REQ-016 OUT_READY  input  1  downstream accepts the result.

Function
REQ-017 The FSM SHALL have the states IDLE, ISSUE, WAIT and HOLD.
REQ-018 In IDLE, the grant SHALL be the sole valid channel, or, when both are valid, the channel not granted last (round-robin); after reset, channel 0 wins the first tie.
REQ-019 CHx_READY SHALL be combinational and high only in IDLE for the granted channel; the transfer occurs when CHx_VALID and CHx_READY are both high.
REQ-020 On transfer: CHx_DATA latched into FILT_DATA, FILT_SEL set to x, last-grant pointer set to x, next state ISSUE.
REQ-021 ISSUE lasts exactly one cycle with FILT_ENABLE=1; FILT_ENABLE SHALL be 0 in every other state.
REQ-022 WAIT SHALL last FILT_LAT cycles (4-bit down-counter); FILT_DATA and FILT_SEL SHALL hold from transfer until the next transfer.
REQ-023 At the end of the last WAIT cycle, the per-channel decimation counter dec[FILT_SEL] (8-bit) SHALL advance.
REQ-024 Decimation rule, non-final sample: if dec[FILT_SEL] != DECIM-1, increment and return to IDLE.
REQ-025 Decimation rule, final sample: if dec[FILT_SEL] == DECIM-1, wrap to 0, register FILT_OUT into OUT_DATA and FILT_SEL into OUT_CH, set OUT_VALID=1, go to HOLD.
REQ-026 HOLD SHALL keep OUT_VALID, OUT_DATA and OUT_CH stable until OUT_READY=1; on that edge OUT_VALID clears and the FSM goes to IDLE, so HOLD lasts 1 cycle minimum.
REQ-027 Latency: transfer in cycle t gives FILT_ENABLE in t+1 and OUT_VALID from t+2+FILT_LAT.
REQ-028 Sustained throughput with OUT_READY=1 is one sample per 2+FILT_LAT cycles (+1 cycle per emitted output).
REQ-029 No channel sample SHALL be dropped or duplicated; samples arriving outside IDLE wait on VALID.
REQ-030 DECIM=1 SHALL emit an output for every sample.
REQ-031 Decimation counters SHALL be independent per channel.

Reset
REQ-032 While RST=0: state IDLE; FILT_DATA=0, FILT_SEL=0, FILT_ENABLE=0, OUT_VALID=0, OUT_CH=0, OUT_DATA=0; dec[0]=dec[1]=0; wait counter=0; last-grant pointer=1.
REQ-033 Reset asserted mid-operation (any state) SHALL abort the sample in flight, producing no output and no later FILT_ENABLE.

Structure
REQ-034 Shared package fir_sched_pkg SHALL hold the state encoding, the sample width (16) and the counter widths.
REQ-035 The round-robin grant logic SHALL be one sub-module, rr_arb2.

Verification
REQ-036 Reset and tie: reset, then CH0_VALID=CH1_VALID=1 -> grants 0,1,0,1; FILT_SEL follows the grant order.
REQ-037 Timing: DECIM=1, FILT_LAT=2, CH0 sends 0x4000 at cycle t -> FILT_ENABLE at t+1 and OUT_VALID at t+4 with OUT_DATA = FILT_OUT sampled at the end of t+3, OUT_CH=0.
REQ-038 Decimation: DECIM=8, 100-sample-period sine on CH0 only -> exactly 1 output per 8 accepted samples, 125 outputs per 1000 samples.
REQ-039 Backpressure: OUT_READY=0 for 20 cycles during HOLD -> OUT_* stable, both READY=0, no FILT_ENABLE; release -> IDLE next cycle.
REQ-040 Reset mid-WAIT: RST=0 during WAIT -> all outputs zero, no OUT_VALID afterwards; the next sample restarts dec at 0.
